// File: rtl/pc_sequencer.sv
// Fetch sequencer: steers the program counter, issues instruction-memory fetches
// and buffers {pc, instruction} pairs in a small FIFO for decode.
module pc_sequencer #(
  parameter int FIFO_DEPTH = 2,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] pc_address,
  output logic [1:0]        pc_op,
  output logic [ADDR_W-1:0] pc_target,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [ADDR_W-1:0] imem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [ADDR_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_pc
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [1:0] OP_INC  = 2'b00;
  localparam logic [1:0] OP_LOAD = 2'b01;
  localparam logic [1:0] OP_HOLD = 2'b10;
  localparam logic [1:0] OP_CLR  = 2'b11;

  typedef enum logic [1:0] {S_INIT, S_FETCH, S_DISCARD} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] inst;
  } entry_t;

  state_t             state, state_nxt;
  entry_t             mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               not_full, push, pop, flush;

  assign not_full   = count < CNT_W'(FIFO_DEPTH);
  assign imem_addr  = pc_address;
  assign inst_valid = count != '0;
  assign inst_pc    = mem[rd_ptr].pc;
  assign inst_data  = mem[rd_ptr].inst;
  // A redirect empties the FIFO, so a coincident pop must not also move rd_ptr.
  assign pop        = inst_valid && inst_ready && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_INIT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pc_op     = OP_HOLD;
    pc_target = '0;
    imem_req  = 1'b0;
    push      = 1'b0;
    flush     = 1'b0;
    case (state)
      S_INIT: begin
        state_nxt = S_FETCH;
        // rst_n gate keeps pc_op/pc_target at their reset values while held in reset
        if (redirect_valid && rst_n) begin
          pc_op     = OP_LOAD;
          pc_target = redirect_target;
          flush     = 1'b1;
        end else begin
          pc_op = OP_CLR;
        end
      end
      S_FETCH: begin
        imem_req = not_full;
        if (redirect_valid) begin
          pc_op     = OP_LOAD;
          pc_target = redirect_target;
          flush     = 1'b1;
          if (imem_req && !imem_ack) state_nxt = S_DISCARD;
        end else if (imem_req && imem_ack) begin
          push  = 1'b1;
          pc_op = OP_INC;
        end
      end
      S_DISCARD: begin
        // The request stays up at the new PC; whatever returns belongs to the old one.
        imem_req = 1'b1;
        if (redirect_valid) begin
          pc_op     = OP_LOAD;
          pc_target = redirect_target;
          flush     = 1'b1;
        end
        if (imem_ack) state_nxt = S_FETCH;
      end
      default: state_nxt = S_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= '{pc: pc_address, inst: imem_rdata};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Drives the program counter's 2-bit operation select and load target, and fetches the instruction at the current PC from instruction memory.
- Buffers fetched instructions in a small FIFO for decode.
- Handles stalls (FIFO full) and control-flow redirects (branch/jump) by flushing and reloading the PC.
- Sits between the program counter, the instruction memory port and the decode stage.

Parameters:
FIFO_DEPTH, 2, number of buffered {pc, instruction} entries; power of two, minimum 2.
ADDR_W, 32, address and instruction width.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst_n  input  1  asynchronous, active-low reset.
pc_address  input  ADDR_W  current PC value; the program counter updates it at the clock edge after pc_op is applied.
pc_op  output  2  PC operation: 00 = +4, 01 = load pc_target, 10 = hold, 11 = clear to 0.
pc_target  output  ADDR_W  load value for pc_op=01.
imem_req  output  1  fetch request; held high until imem_ack.
imem_addr  output  ADDR_W  fetch address; equals pc_address while imem_req=1.
imem_ack  input  1  one-cycle completion strobe; imem_rdata is valid in the same cycle.
imem_rdata  input  ADDR_W  fetched instruction.
redirect_valid  input  1  one-cycle branch/jump taken strobe.
redirect_target  input  ADDR_W  new PC for a redirect.
inst_valid  output  1  FIFO head is valid.
inst_ready  input  1  decode accepts the head; pop occurs when inst_valid && inst_ready.
inst_data  output  ADDR_W  head instruction.
inst_pc  output  ADDR_W  PC of the head instruction.

Behaviour:
- Reset: clock is clk; reset is asynchronous, active-low rst_n.
  - While rst_n=0: state=S_INIT, FIFO count=0, imem_req=0, inst_valid=0, pc_op=11, pc_target=0.
  - inst_data and inst_pc read 0 when the FIFO is empty after reset.
- Outputs: pc_op, pc_target and imem_req are combinational from state and current inputs. FIFO outputs come from registers.
- States and transitions:
  - S_INIT: pc_op=11 for exactly one cycle after reset release, then go to S_FETCH. A redirect in this cycle takes priority: pc_op=01, pc_target=redirect_target.
  - S_FETCH:
    - If count<FIFO_DEPTH: imem_req=1, imem_addr=pc_address, pc_op=10 until ack.
    - On imem_ack (no redirect): push {pc_address, imem_rdata}, pc_op=00, stay in S_FETCH. The next request issues in the following cycle with the incremented PC, giving 1 instruction/cycle throughput when ack is immediate.
    - If count==FIFO_DEPTH: imem_req=0, pc_op=10 (stall).
  - S_DISCARD: a request was outstanding when a redirect arrived. Keep imem_req=1 at the already-loaded new PC; on imem_ack, drop the data, pc_op=10, go to S_FETCH and re-request.
- Redirect (highest priority in every state except reset):
  - pc_op=01, pc_target=redirect_target, FIFO count cleared that edge. A simultaneous pop is ignored.
  - In S_FETCH with imem_req=1 and no ack: go to S_DISCARD.
  - With ack in the same cycle: drop the data, no push, stay in S_FETCH.
  - Redirect while in S_DISCARD: reload the PC again and stay in S_DISCARD.
- FIFO:
  - A push never overflows: requests issue only when count<FIFO_DEPTH, and only one request is outstanding.
  - Simultaneous push and pop: count unchanged.
  - Read and write pointers wrap modulo FIFO_DEPTH.
  - Pop when empty has no effect.
- imem_req must never deassert before imem_ack. The memory may take any number of cycles.
- Asserting reset mid-request drops imem_req immediately. The memory side must tolerate an abandoned request.

Test Plan:
- Reset release, imem_ack tied high, inst_ready=1 → cycle 0 pc_op=11; then pc_op=00 every cycle; inst_pc sequence 0,4,8,12; inst_data matches the memory model.
- inst_ready=0, FIFO_DEPTH=2 → two pushes (pc 0,4), then imem_req=0 and pc_op=10. Raise inst_ready → fetch resumes at pc 8.
- imem_ack delayed 3 cycles → imem_req and imem_addr stable for 4 cycles, pc_op=10 for 3 cycles then 00; exactly one push.
- redirect_valid with target 0x100 while a request is outstanding → pc_op=01, FIFO emptied, old ack data dropped, next push has inst_pc=0x100.
- Redirect coincident with imem_ack and a pop, FIFO holding 1 entry → count=0, no push, pc_op=01; next fetch at the target.
- rst_n pulsed low mid-request with FIFO full → immediately imem_req=0, inst_valid=0, pc_op=11; restart fetch from pc 0.
